// File: rtl/mult_rr_scheduler_if.sv
// Bundle of the request, multiplier and response signals of the shared-multiplier scheduler.
interface mult_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic [15:0]       mul_out;
    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [15:0]       rsp_data;
    logic              rsp_ready;

    // Environment side: requesters, the multiplier instance and the response consumer.
    modport master (
        output req_valid, req_a, req_b, mul_out, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, mul_out, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one registered 8x8 multiplier among NREQ requesters.
// One operation in flight: IDLE (arbitrate/accept) -> ISSUE -> CAPT -> RESP -> IDLE.
module mult_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_rr_scheduler_if.slave   bus,
    output logic                 busy,
    output logic [15:0]          op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] id_q;
    logic [7:0]      op_a_q;
    logic [7:0]      op_b_q;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [15:0]     rsp_data_q;
    logic [15:0]     op_count_q;

    logic            grant_vld;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] search_idx;
    logic [7:0]      sel_a;
    logic [7:0]      sel_b;
    logic [ID_W-1:0] ptr_d;

    // Round-robin search: first valid request at or after ptr_q, wrapping modulo NREQ.
    always_comb begin
        grant_vld  = 1'b0;
        grant_id   = '0;
        search_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            search_idx = ID_W'((32'(ptr_q) + k) % NREQ);
            if (!grant_vld && bus.req_valid[search_idx]) begin
                grant_vld = 1'b1;
                grant_id  = search_idx;
            end
        end
    end

    // One-hot accept strobe, only while idle; held low during reset.
    always_comb begin
        bus.req_ready = '0;
        if (rst && state_q == IDLE && grant_vld) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    // Operand mux for the granted requester and pointer advance past the served ID.
    always_comb begin
        sel_a = bus.req_a[32'(grant_id)*8 +: 8];
        sel_b = bus.req_b[32'(grant_id)*8 +: 8];
        ptr_d = (32'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
    end

    // Scheduler FSM with all datapath and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        op_a_q  <= sel_a;
                        op_b_q  <= sel_b;
                        id_q    <= grant_id;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= CAPT;
                end
                CAPT: begin
                    rsp_data_q  <= bus.mul_out;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        ptr_q       <= ptr_d;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Operand registers change only on accept, so they already hold during ISSUE.
    assign bus.mul_a     = op_a_q;
    assign bus.mul_b     = op_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q != IDLE);
    assign op_count      = op_count_q;

endmodule
